lc3b_mem_responder: RTL and testbench

//  Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake issued by the datapath.

---
 rtl/lc3b_mem_responder.sv | 117 +++++++++++
 tb/tb_lc3b_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: word array answering mem_read/mem_write with a
// single-cycle mem_resp a fixed LATENCY after acceptance, with byte-masked writes.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    input  logic [1:0]           mem_byte_enable,
    output logic                 mem_resp,
    output logic [15:0]          mem_rdata,
    output logic                 proto_err,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [15:0]          load_data,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic                 r_op_write;
    logic [ADDR_BITS-1:0] r_idx;
    logic [15:0]          r_wdata;
    logic [1:0]           r_be;
    logic [15:0]          r_data;
    logic [15:0]          r_rdata_hold;
    logic                 r_proto_err;
    logic [15:0]          r_mem [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_accept;
    logic                 w_req_match;
    logic                 w_unused_addr;

    // Word index from the byte address; upper bits alias.
    assign w_idx         = mem_address[ADDR_BITS:1];
    assign w_unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};
    assign w_accept      = (r_state == S_IDLE) && (mem_read ^ mem_write);
    assign w_req_match   = (mem_write == r_op_write) && (mem_read == !r_op_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read data is driven from the latched word during RESP, otherwise the held value.
    always_comb begin
        mem_resp  = (r_state == S_RESP);
        mem_rdata = r_rdata_hold;
        if ((r_state == S_RESP) && !r_op_write) mem_rdata = r_data;
        proto_err = r_proto_err;
        dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= 4'd0;
            r_op_write   <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 16'h0000;
            r_be         <= 2'b00;
            r_data       <= 16'h0000;
            r_rdata_hold <= 16'h0000;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_write <= mem_write;
                r_idx      <= w_idx;
                r_wdata    <= mem_wdata;
                r_be       <= mem_byte_enable;
                r_cnt      <= CNT_INIT;
                if (mem_read) r_data <= r_mem[w_idx];
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == S_RESP) && !r_op_write) r_rdata_hold <= r_data;
            if ((r_state == S_IDLE) && mem_read && mem_write) r_proto_err <= 1'b1;
            if ((r_state != S_IDLE) && !w_req_match) r_proto_err <= 1'b1;
        end
    end

    // Commit at the edge ending RESP; the later backdoor assignment wins on a collision.
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && r_op_write) begin
            if (r_be[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
            if (r_be[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
        end
        if (load_en) r_mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized scoreboard bench for lc3b_mem_responder with a word-array reference model.
module tb_lc3b_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write, mem_resp, proto_err, load_en;
  logic [15:0] mem_address, mem_wdata, mem_rdata, load_data;
  logic [1:0]  mem_byte_enable, dbg_state;
  logic [7:0]  load_addr;

  logic        d1_read, d1_write, d1_resp, d1_perr, d1_load_en;
  logic [15:0] d1_addr, d1_wdata, d1_rdata, d1_load_data;
  logic [1:0]  d1_be, d1_dbg;
  logic [7:0]  d1_load_addr;

  logic [31:0] cyc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;
  logic [15:0] model [256];
  logic [15:0] d1_model [256];
  logic [15:0] last_rd;
  logic        bd_on_commit;
  logic [15:0] bd_data;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .proto_err(proto_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .dbg_state(dbg_state)
  );

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .mem_read(d1_read), .mem_write(d1_write),
    .mem_address(d1_addr), .mem_wdata(d1_wdata), .mem_byte_enable(d1_be),
    .mem_resp(d1_resp), .mem_rdata(d1_rdata), .proto_err(d1_perr),
    .load_en(d1_load_en), .load_addr(d1_load_addr), .load_data(d1_load_data), .dbg_state(d1_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  function automatic int word_of(input logic [15:0] addr);
    return (int'(addr) / 2) % 256;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; load_en = 1'b0;
    exp_q.delete();
    last_rd = 16'h0000;
    #1 check("rst_resp", {31'd0, mem_resp}, 32'd0);
    @(negedge clk);
    check("rst_rdata", {16'd0, mem_rdata}, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input int idx, input logic [15:0] data);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    load_en = 1'b1; load_addr = 8'(idx); load_data = data;
    model[idx] = data;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; load_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_req(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input bit drop);
    int          idx;
    logic [31:0] acc;
    logic [15:0] exp_d;
    bit          got;
    idx = word_of(addr);
    @(negedge clk);
    load_en = 1'b0;
    mem_read = !is_wr; mem_write = is_wr;
    mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    acc = cyc + 32'd1;
    if (is_wr) model[idx] = merge(model[idx], wd, be);
    else last_rd = model[idx];
    exp_d = last_rd;
    exp_q.push_back({acc + 32'(LAT) - 32'd1, exp_d});
    if (drop) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      mem_address = ~addr; mem_wdata = ~wd;
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (bd_on_commit) begin
      load_en = 1'b1; load_addr = 8'(idx); load_data = bd_data;
      model[idx] = bd_data;
      bd_on_commit = 1'b0;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: no mem_resp for addr %0h, expected one", addr);
    end
    @(posedge clk);
  endtask

  task automatic d1_load(input int idx, input logic [15:0] data);
    @(negedge clk);
    d1_load_en = 1'b1; d1_load_addr = 8'(idx); d1_load_data = data;
    d1_model[idx] = data;
    @(negedge clk);
    d1_load_en = 1'b0;
  endtask

  task automatic d1_req(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd);
    int          idx;
    logic [31:0] acc;
    bit          got;
    idx = word_of(addr);
    @(negedge clk);
    d1_read = !is_wr; d1_write = is_wr; d1_addr = addr; d1_wdata = wd; d1_be = 2'b11;
    acc = cyc + 32'd1;
    if (is_wr) d1_model[idx] = wd;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d1_resp === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("lat1_resp_cycle", got ? cyc : 32'hFFFF_FFFF, acc);
    if (!is_wr) check("lat1_rdata", {16'd0, d1_rdata}, {16'd0, d1_model[idx]});
    @(posedge clk);
    @(negedge clk);
    d1_read = 1'b0; d1_write = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mem_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_resp: mem_resp=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_cycle", cyc, mon_e[47:16]);
        check("rdata", {16'd0, mem_rdata}, {16'd0, mon_e[15:0]});
      end
    end
  end

  initial begin
    logic [15:0] addr, wd;
    bit          saw;
    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0; mem_wdata = 16'h0;
    mem_byte_enable = 2'b00; load_en = 1'b0; load_addr = 8'h0; load_data = 16'h0;
    d1_read = 1'b0; d1_write = 1'b0; d1_addr = 16'h0; d1_wdata = 16'h0; d1_be = 2'b00;
    d1_load_en = 1'b0; d1_load_addr = 8'h0; d1_load_data = 16'h0;
    bd_on_commit = 1'b0; bd_data = 16'h0; last_rd = 16'h0;

    do_reset();
    for (int i = 0; i < 256; i++) load(i, 16'($urandom));

    // directed: basic read, byte enables, back-to-back, backdoor collision
    load(16'h10, 16'h1234);
    idle(1);
    do_req(1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);
    do_req(1'b1, 16'h0020, 16'hABCD, 2'b01, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);
    load(16'h10, 16'h1234);
    do_req(1'b1, 16'h0020, 16'hABCD, 2'b10, 1'b0);
    do_req(1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);
    do_req(1'b1, 16'h0030, 16'hFFFF, 2'b00, 1'b0);
    do_req(1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0);
    do_req(1'b1, 16'h0004, 16'h5555, 2'b11, 1'b0);
    do_req(1'b0, 16'h0004, 16'h0000, 2'b00, 1'b0);
    bd_on_commit = 1'b1; bd_data = 16'h4242;
    do_req(1'b1, 16'h000A, 16'h1111, 2'b11, 1'b0);
    do_req(1'b0, 16'h000A, 16'h0000, 2'b00, 1'b0);

    // random traffic with aliasing addresses and idle-time backdoor loads
    for (int i = 0; i < 150; i++) begin
      addr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) addr = (addr & 16'hFE01) | 16'($urandom_range(0, 7) * 2);
      wd = 16'($urandom);
      do_req(1'($urandom_range(0, 1)), addr, wd, 2'($urandom_range(0, 3)), 1'b0);
      case ($urandom_range(0, 3))
        0: idle($urandom_range(0, 3));
        1: begin
          idle(0);
          load($urandom_range(0, 7), 16'($urandom));
        end
        default: ;
      endcase
    end
    idle(2);
    check("proto_err_clean", {31'd0, proto_err}, 32'd0);

    // request dropped mid-flight still completes with latched values
    do_req(1'b1, 16'h0040, 16'h2468, 2'b11, 1'b1);
    idle(1);
    check("proto_err_drop", {31'd0, proto_err}, 32'd1);
    do_req(1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);
    do_reset();

    // read and write together in IDLE
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h0010;
    saw = 1'b0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (mem_resp === 1'b1) saw = 1'b1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    check("illegal_no_resp", {31'd0, saw}, 32'd0);
    check("proto_err_both", {31'd0, proto_err}, 32'd1);
    do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0);
    idle(1);
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

    // reset during BUSY drops the write
    load(4, 16'h0001);
    @(negedge clk);
    load_en = 1'b0;
    mem_write = 1'b1; mem_read = 1'b0; mem_address = 16'h0008;
    mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
    @(negedge clk);
    do_reset();
    do_req(1'b0, 16'h0008, 16'h0000, 2'b00, 1'b0);
    idle(2);

    // LATENCY=1 instance: aliasing and next-cycle response
    d1_load(1, 16'hBEEF);
    d1_req(1'b0, 16'h0002, 16'h0000);
    d1_req(1'b0, 16'h0202, 16'h0000);
    d1_req(1'b1, 16'h0202, 16'h7777);
    d1_req(1'b0, 16'h0002, 16'h0000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
